// File: rtl/stall_controller.sv
// D-stage hazard unit: shadow E/M/W {dest, Tnew} pipeline drives the stall and
// D operand forwarding selects; a HI/LO busy counter holds back HI/LO users.
module stall_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Tuse_rs,
  input  logic [1:0] Tuse_rt,
  input  logic [1:0] Tnew_D,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] A3_D,
  input  logic       MDstart_D,
  input  logic       MDdiv_D,
  input  logic       MDuse_D,
  output logic       Stall,
  output logic [1:0] Fwd_rs_D,
  output logic [1:0] Fwd_rt_D,
  output logic       Busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  logic [4:0] a3_e, a3_m, a3_w;
  logic [1:0] tnew_e, tnew_m, tnew_w;
  logic       start_e, div_e;
  logic [3:0] cnt;

  logic       stall_rs, stall_rt, stall_md;

  // Tnew counts down as the producer advances and sticks at 0 once ready.
  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
    return (r != 5'd0) && (r == a3);
  endfunction

  function automatic logic reg_stall(
    input logic [4:0] r, input logic [1:0] tuse,
    input logic [4:0] e_a3, input logic [1:0] e_t,
    input logic [4:0] m_a3, input logic [1:0] m_t,
    input logic [4:0] w_a3, input logic [1:0] w_t);
    return (hit(r, e_a3) && (e_t > tuse)) ||
           (hit(r, m_a3) && (m_t > tuse)) ||
           (hit(r, w_a3) && (w_t > tuse));
  endfunction

  // Nearest producer wins; an E-stage hit selects the regfile because the
  // value is not ready yet and a later-stage forward will pick it up.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] r,
    input logic [4:0] e_a3,
    input logic [4:0] m_a3, input logic [1:0] m_t,
    input logic [4:0] w_a3, input logic [1:0] w_t);
    if (hit(r, e_a3))                     return FWD_RF;
    else if (hit(r, m_a3) && m_t == 2'd0) return FWD_M;
    else if (hit(r, w_a3) && w_t == 2'd0) return FWD_W;
    else                                  return FWD_RF;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_e    <= 5'd0;
      tnew_e  <= 2'd0;
      a3_m    <= 5'd0;
      tnew_m  <= 2'd0;
      a3_w    <= 5'd0;
      tnew_w  <= 2'd0;
      start_e <= 1'b0;
      div_e   <= 1'b0;
      cnt     <= 4'd0;
    end else begin
      a3_e    <= Stall ? 5'd0 : A3_D;
      tnew_e  <= Stall ? 2'd0 : Tnew_D;
      start_e <= MDstart_D & ~Stall;
      div_e   <= MDdiv_D & ~Stall;
      a3_m    <= a3_e;
      tnew_m  <= dec_sat(tnew_e);
      a3_w    <= a3_m;
      tnew_w  <= dec_sat(tnew_m);
      if (start_e)          cnt <= div_e ? DIV_LOAD : MULT_LOAD;
      else if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else                  cnt <= 4'd0;
    end
  end

  always_comb begin
    Busy     = start_e | (cnt != 4'd0);
    stall_rs = reg_stall(rs_D, Tuse_rs, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
    stall_rt = reg_stall(rt_D, Tuse_rt, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
    stall_md = MDuse_D & Busy;
    Stall    = stall_rs | stall_rt | stall_md;
    Fwd_rs_D = fwd_sel(rs_D, a3_e, a3_m, tnew_m, a3_w, tnew_w);
    Fwd_rt_D = fwd_sel(rt_D, a3_e, a3_m, tnew_m, a3_w, tnew_w);
  end

endmodule

// File: tb/tb_stall_controller.sv
// Directed bench for stall_controller: a cycle-by-cycle vector table for the
// register hazard/forwarding paths plus hand sequences for HI/LO busy and reset.
module tb_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Tuse_rs, Tuse_rt, Tnew_D;
  logic [4:0] rs_D, rt_D, A3_D;
  logic       MDstart_D, MDdiv_D, MDuse_D;
  logic       Stall, Busy;
  logic [1:0] Fwd_rs_D, Fwd_rt_D;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] tuse_rs, tuse_rt, tnew;
    logic [4:0] rs, rt, a3;
    logic       exp_stall;
    logic [1:0] exp_fwd_rs, exp_fwd_rt;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  stall_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .Tnew_D(Tnew_D),
    .rs_D(rs_D), .rt_D(rt_D), .A3_D(A3_D),
    .MDstart_D(MDstart_D), .MDdiv_D(MDdiv_D), .MDuse_D(MDuse_D),
    .Stall(Stall), .Fwd_rs_D(Fwd_rs_D), .Fwd_rt_D(Fwd_rt_D), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                     input logic [1:0] tnew, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] a3,
                     input logic st, input logic [1:0] frs,
                     input logic [1:0] frt);
    vec_t v;
    v.tuse_rs = tuse_rs; v.tuse_rt = tuse_rt; v.tnew = tnew;
    v.rs = rs; v.rt = rt; v.a3 = a3;
    v.exp_stall = st; v.exp_fwd_rs = frs; v.exp_fwd_rt = frt; v.exp_busy = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    Tuse_rs = 2'b11; Tuse_rt = 2'b11; Tnew_D = 2'd0;
    rs_D = 5'd0; rt_D = 5'd0; A3_D = 5'd0;
    MDstart_D = 1'b0; MDdiv_D = 1'b0; MDuse_D = 1'b0;
  endtask

  task automatic drive_md(input logic start, input logic div);
    drive_idle();
    MDstart_D = start; MDdiv_D = div; MDuse_D = 1'b1;
  endtask

  // Counts consecutive stalled cycles of the instruction currently in D,
  // checking Busy tracks the stall, and leaves it issuing on the next edge.
  task automatic count_stalls(input string name, input int exp_n);
    int n = 0;
    @(negedge clk);
    while (Stall === 1'b1 && n < 40) begin
      check({name, "_busy"}, n, {3'b0, Busy}, 4'd1);
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check({name, "_cycles"}, 0, 4'(n), 4'(exp_n));
    check({name, "_busy_low"}, 0, {3'b0, Busy}, 4'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    check("rst_stall", 0, {3'b0, Stall}, 4'd0);
    check("rst_fwd_rs", 0, {2'b0, Fwd_rs_D}, 4'd0);
    check("rst_busy", 0, {3'b0, Busy}, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //  tuse_rs tuse_rt tnew rs rt a3  stall frs   frt
    add(2'd1, 2'd3, 2'd2, 5'd2, 5'd0, 5'd1, 1'b0, 2'b00, 2'b00); // lw $1
    add(2'd1, 2'd1, 2'd1, 5'd1, 5'd3, 5'd4, 1'b1, 2'b00, 2'b00); // addu: lw in E
    add(2'd1, 2'd1, 2'd1, 5'd1, 5'd3, 5'd4, 1'b0, 2'b00, 2'b00); // lw in M Tnew1
    add(2'd0, 2'd1, 2'd0, 5'd1, 5'd4, 5'd0, 1'b0, 2'b01, 2'b00); // W fwd $1
    add(2'd0, 2'd3, 2'd1, 5'd4, 5'd0, 5'd1, 1'b0, 2'b10, 2'b00); // addu $1, M fwd $4
    add(2'd0, 2'd0, 2'd0, 5'd1, 5'd4, 5'd0, 1'b1, 2'b00, 2'b01); // beq: addu in E
    add(2'd0, 2'd0, 2'd0, 5'd1, 5'd4, 5'd0, 1'b0, 2'b10, 2'b00); // addu in M
    add(2'd0, 2'd0, 2'd2, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00); // A3=0 Tnew2
    add(2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00); // rs=$0 vs E a3=0
    add(2'd3, 2'd3, 2'd1, 5'd0, 5'd0, 5'd5, 1'b0, 2'b00, 2'b00); // alu $5
    add(2'd3, 2'd3, 2'd1, 5'd0, 5'd0, 5'd5, 1'b0, 2'b00, 2'b00); // alu $5
    add(2'd3, 2'd1, 2'd0, 5'd0, 5'd5, 5'd0, 1'b0, 2'b00, 2'b00); // E wins over M
    add(2'd3, 2'd1, 2'd0, 5'd0, 5'd5, 5'd0, 1'b0, 2'b00, 2'b10); // M fwd $5
    add(2'd3, 2'd1, 2'd0, 5'd0, 5'd5, 5'd0, 1'b0, 2'b00, 2'b01); // W fwd, Tnew sat 0
    add(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd7, 1'b0, 2'b00, 2'b00); // lw $7
    add(2'd3, 2'd2, 2'd0, 5'd7, 5'd7, 5'd0, 1'b0, 2'b00, 2'b00); // Tuse never / equal

    for (int i = 0; i < vecs.size(); i++) begin
      drive_idle();
      Tuse_rs = vecs[i].tuse_rs; Tuse_rt = vecs[i].tuse_rt; Tnew_D = vecs[i].tnew;
      rs_D = vecs[i].rs; rt_D = vecs[i].rt; A3_D = vecs[i].a3;
      @(negedge clk);
      check("vec_stall", i, {3'b0, Stall}, {3'b0, vecs[i].exp_stall});
      check("vec_fwd_rs", i, {2'b0, Fwd_rs_D}, {2'b0, vecs[i].exp_fwd_rs});
      check("vec_fwd_rt", i, {2'b0, Fwd_rt_D}, {2'b0, vecs[i].exp_fwd_rt});
      check("vec_busy", i, {3'b0, Busy}, {3'b0, vecs[i].exp_busy});
      @(posedge clk); #1;
    end

    // mult issues, mflo waits 1 + MULT_CYCLES
    drive_md(1'b1, 1'b0);
    @(negedge clk);
    check("mult_issue_stall", 0, {3'b0, Stall}, 4'd0);
    @(posedge clk); #1;
    drive_md(1'b0, 1'b0);
    count_stalls("mflo_after_mult", 6);

    // div then mflo: 1 + DIV_CYCLES
    drive_md(1'b1, 1'b1);
    @(posedge clk); #1;
    drive_md(1'b0, 1'b0);
    count_stalls("mflo_after_div", 11);

    // mult held back by Busy starts only once it issues
    drive_md(1'b1, 1'b0);
    @(posedge clk); #1;
    drive_md(1'b1, 1'b0);
    count_stalls("mult_held", 6);
    drive_md(1'b0, 1'b0);
    count_stalls("mflo_after_held", 6);

    // reset three cycles into a div
    drive_md(1'b1, 1'b1);
    @(posedge clk); #1;
    drive_md(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("div_pre_rst_stall", i, {3'b0, Stall}, 4'd1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 0, {3'b0, Busy}, 4'd0);
    check("rst_mid_stall", 0, {3'b0, Stall}, 4'd0);
    @(posedge clk); #1;
    check("rst_hold_busy", 0, {3'b0, Busy}, 4'd0);
    check("rst_hold_stall", 0, {3'b0, Stall}, 4'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_stall", 0, {3'b0, Stall}, 4'd0);
    check("post_rst_busy", 0, {3'b0, Busy}, 4'd0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("post_rst_idle_busy", 0, {3'b0, Busy}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
